// File: rtl/k12a_mem_arbiter_pkg.sv
// rtl/k12a_mem_arbiter_pkg.sv - shared k12a memory bus types
//
// Purpose: memory access mode and arbiter state encodings shared by the
// arbiter, its wait counter and anything that drives the k12a memory bus.
// Ports: none (package).
package k12a_mem_arbiter_pkg;

   typedef enum logic {
      MEM_MODE_READ  = 1'b0,
      MEM_MODE_WRITE = 1'b1
   } mem_mode_t;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_CPU  = 2'd1,
      ARB_DMA  = 2'd2
   } arb_state_t;

   // Bits needed to hold 0..max_val; never narrower than one bit so a
   // zero-valued parameter still yields a legal vector.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/k12a_mem_arbiter_wait_counter.sv
// rtl/k12a_mem_arbiter_wait_counter.sv - loadable wait-state down-counter
//
// Purpose: counts the wait states of one bus access. Loaded with WAIT_STATES
// when an access is granted, decremented every access cycle, and flags the
// completion cycle with zero.
// Ports:
//   clock    in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   load     in   reload the counter with WAIT_STATES
//   dec      in   decrement (holds at zero)
//   zero     out  counter is zero
module k12a_wait_counter
   import k12a_mem_arbiter_pkg::*;
#(
   parameter int WAIT_STATES = 1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int             CW       = cnt_width(WAIT_STATES);
   localparam logic [CW-1:0]  LOAD_VAL = CW'(WAIT_STATES);

   logic [CW-1:0] count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (dec && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/k12a_mem_arbiter.sv
// rtl/k12a_mem_arbiter.sv - CPU/DMA arbiter for the k12a memory bus
//
// Purpose: shares the 8-bit memory bus between the CPU and a DMA requester,
// inserts WAIT_STATES wait cycles per access, stalls the CPU while it does
// not own the bus, and lets DMA win a tie after STARVE_LIMIT CPU wins.
// Ports:
//   clock, reset_n                      clock / async active-low reset
//   cpu_mem_enable, cpu_mem_mode,
//   cpu_addr, cpu_wdata                 CPU request (level, held to completion)
//   cpu_rdata, cpu_stall                CPU read data / stall
//   dma_req, dma_mode, dma_addr,
//   dma_wdata                           DMA request (level, held to completion)
//   dma_grant, dma_done, dma_rdata      DMA ownership / completion pulse / data
//   mem_enable, mem_mode, mem_addr,
//   mem_wdata, mem_rdata                memory device bus
module k12a_mem_arbiter
   import k12a_mem_arbiter_pkg::*;
#(
   parameter int WAIT_STATES  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cpu_mem_enable,
   input  mem_mode_t   cpu_mem_mode,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  mem_mode_t   dma_mode,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   output logic        dma_grant,
   output logic        dma_done,
   output logic [7:0]  dma_rdata,
   output logic        mem_enable,
   output mem_mode_t   mem_mode,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata
);

   localparam int            SW         = cnt_width(STARVE_LIMIT);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   arb_state_t    state;
   arb_state_t    state_next;
   logic [SW-1:0] starve_cnt;
   logic [SW-1:0] starve_next;
   logic          wait_load;
   logic          wait_dec;
   logic          wait_zero;

   k12a_wait_counter #(
      .WAIT_STATES (WAIT_STATES)
   ) u_wait_counter (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (wait_load),
      .dec     (wait_dec),
      .zero    (wait_zero)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ARB_IDLE;
         starve_cnt <= '0;
      end else begin
         state      <= state_next;
         starve_cnt <= starve_next;
      end
   end

   // Arbitration happens only from ARB_IDLE, so every access is followed by
   // at least one idle cycle. starve_cnt counts CPU wins over a waiting DMA;
   // it only increments below STARVE_MAX, which gives the saturation.
   always_comb begin
      state_next  = state;
      starve_next = starve_cnt;
      wait_load   = 1'b0;
      wait_dec    = (state != ARB_IDLE);
      case (state)
         ARB_IDLE: begin
            if (cpu_mem_enable && dma_req) begin
               if (starve_cnt < STARVE_MAX) begin
                  state_next  = ARB_CPU;
                  starve_next = starve_cnt + SW'(1);
               end else begin
                  state_next  = ARB_DMA;
                  starve_next = '0;
               end
            end else if (cpu_mem_enable) begin
               state_next = ARB_CPU;
            end else if (dma_req) begin
               state_next  = ARB_DMA;
               starve_next = '0;
            end
            wait_load = (state_next != ARB_IDLE);
         end
         ARB_CPU, ARB_DMA: begin
            // The owner must hold its request; the access runs to its
            // completion cycle whatever the request lines do.
            if (wait_zero) begin
               state_next = ARB_IDLE;
            end
         end
         default: begin
            state_next = ARB_IDLE;
         end
      endcase
   end

   // Bus mux: the owner's request drives the memory bus combinationally so
   // devices see it stable for the whole access; idle bus is parked at zero.
   always_comb begin
      mem_enable = 1'b0;
      mem_mode   = MEM_MODE_READ;
      mem_addr   = '0;
      mem_wdata  = '0;
      cpu_rdata  = '0;
      dma_rdata  = '0;
      case (state)
         ARB_CPU: begin
            mem_enable = 1'b1;
            mem_mode   = cpu_mem_mode;
            mem_addr   = cpu_addr;
            mem_wdata  = cpu_wdata;
            cpu_rdata  = mem_rdata;
         end
         ARB_DMA: begin
            mem_enable = 1'b1;
            mem_mode   = dma_mode;
            mem_addr   = dma_addr;
            mem_wdata  = dma_wdata;
            dma_rdata  = mem_rdata;
         end
         default: begin
         end
      endcase
   end

   // Stall is purely combinational so a CPU that is not requesting is never
   // stalled, even during reset.
   assign cpu_stall = cpu_mem_enable && !((state == ARB_CPU) && wait_zero);
   assign dma_grant = (state == ARB_DMA);
   assign dma_done  = dma_grant && wait_zero;

endmodule

// File: tb/tb_k12a_mem_arbiter.sv
// tb/tb_k12a_mem_arbiter.sv - self-checking bench for k12a_mem_arbiter
module tb_k12a_mem_arbiter;
   import k12a_mem_arbiter_pkg::*;

   typedef struct {
      logic        is_dma;
      mem_mode_t   mode;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
   } exp_t;

   logic        clock;
   logic        reset_n;
   logic        cpu_mem_enable;
   mem_mode_t   cpu_mem_mode;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        dma_req;
   mem_mode_t   dma_mode;
   logic [15:0] dma_addr;
   logic [7:0]  dma_wdata;

   // a: WAIT_STATES=1 STARVE_LIMIT=4; b: WAIT_STATES=1 STARVE_LIMIT=0;
   // c: WAIT_STATES=0 STARVE_LIMIT=4
   logic [7:0]  cpu_rdata_a, cpu_rdata_b, cpu_rdata_c;
   logic        cpu_stall_a, cpu_stall_b, cpu_stall_c;
   logic        dma_grant_a, dma_grant_b, dma_grant_c;
   logic        dma_done_a, dma_done_b, dma_done_c;
   logic [7:0]  dma_rdata_a, dma_rdata_b, dma_rdata_c;
   logic        mem_enable_a, mem_enable_b, mem_enable_c;
   mem_mode_t   mem_mode_a, mem_mode_b, mem_mode_c;
   logic [15:0] mem_addr_a, mem_addr_b, mem_addr_c;
   logic [7:0]  mem_wdata_a, mem_wdata_b, mem_wdata_c;
   logic [7:0]  mem_rdata_a, mem_rdata_b, mem_rdata_c;

   int   vectors     = 0;
   int   miscompares = 0;
   int   mon_sel     = 0;
   exp_t sb[$];

   function automatic logic [7:0] mem_model(input logic [15:0] a);
      return a[15:8] ^ a[7:0] ^ 8'hCA;
   endfunction

   assign mem_rdata_a = mem_model(mem_addr_a);
   assign mem_rdata_b = mem_model(mem_addr_b);
   assign mem_rdata_c = mem_model(mem_addr_c);

   k12a_mem_arbiter #(.WAIT_STATES(1), .STARVE_LIMIT(4)) u_a (
      .clock(clock), .reset_n(reset_n),
      .cpu_mem_enable(cpu_mem_enable), .cpu_mem_mode(cpu_mem_mode), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_a), .cpu_stall(cpu_stall_a),
      .dma_req(dma_req), .dma_mode(dma_mode), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_grant(dma_grant_a), .dma_done(dma_done_a), .dma_rdata(dma_rdata_a),
      .mem_enable(mem_enable_a), .mem_mode(mem_mode_a), .mem_addr(mem_addr_a),
      .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a));

   k12a_mem_arbiter #(.WAIT_STATES(1), .STARVE_LIMIT(0)) u_b (
      .clock(clock), .reset_n(reset_n),
      .cpu_mem_enable(cpu_mem_enable), .cpu_mem_mode(cpu_mem_mode), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_b), .cpu_stall(cpu_stall_b),
      .dma_req(dma_req), .dma_mode(dma_mode), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_grant(dma_grant_b), .dma_done(dma_done_b), .dma_rdata(dma_rdata_b),
      .mem_enable(mem_enable_b), .mem_mode(mem_mode_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b));

   k12a_mem_arbiter #(.WAIT_STATES(0), .STARVE_LIMIT(4)) u_c (
      .clock(clock), .reset_n(reset_n),
      .cpu_mem_enable(cpu_mem_enable), .cpu_mem_mode(cpu_mem_mode), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_c), .cpu_stall(cpu_stall_c),
      .dma_req(dma_req), .dma_mode(dma_mode), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_grant(dma_grant_c), .dma_done(dma_done_c), .dma_rdata(dma_rdata_c),
      .mem_enable(mem_enable_c), .mem_mode(mem_mode_c), .mem_addr(mem_addr_c),
      .mem_wdata(mem_wdata_c), .mem_rdata(mem_rdata_c));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Request-hold rules, checked on the instance the current test targets.
   logic stall_m;
   logic done_m;
   assign stall_m = (mon_sel == 1) ? cpu_stall_b : (mon_sel == 2) ? cpu_stall_c : cpu_stall_a;
   assign done_m  = (mon_sel == 1) ? dma_done_b  : (mon_sel == 2) ? dma_done_c  : dma_done_a;

   a_hold_cpu: assert property (@(posedge clock) disable iff (!reset_n)
      (cpu_mem_enable && stall_m) |=> (cpu_mem_enable || !reset_n))
      else $error("assertion: CPU request dropped before completion");
   a_hold_dma: assert property (@(posedge clock) disable iff (!reset_n)
      (dma_req && !done_m) |=> (dma_req || !reset_n))
      else $error("assertion: DMA request dropped before completion");

   task automatic do_reset(input int sel);
      @(posedge clock);
      #1;
      reset_n        = 1'b0;
      mon_sel        = sel;
      cpu_mem_enable = 1'b0;
      cpu_mem_mode   = MEM_MODE_READ;
      cpu_addr       = '0;
      cpu_wdata      = '0;
      dma_req        = 1'b0;
      dma_mode       = MEM_MODE_READ;
      dma_addr       = '0;
      dma_wdata      = '0;
      sb.delete();
      @(posedge clock);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      cpu_mem_enable = 1'b1;
      #1;
      vectors++; if (mem_enable_a !== 1'b0) begin miscompares++; $display("FAIL reset_mem_enable: got %b want 0", mem_enable_a); end
      vectors++; if (dma_grant_a !== 1'b0) begin miscompares++; $display("FAIL reset_dma_grant: got %b want 0", dma_grant_a); end
      vectors++; if (dma_done_a !== 1'b0) begin miscompares++; $display("FAIL reset_dma_done: got %b want 0", dma_done_a); end
      vectors++; if (mem_mode_a !== MEM_MODE_READ) begin miscompares++; $display("FAIL reset_mem_mode: got %b want 0", mem_mode_a); end
      vectors++; if (mem_addr_a !== 16'h0000) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr_a); end
      vectors++; if (mem_wdata_a !== 8'h00) begin miscompares++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata_a); end
      vectors++; if (cpu_rdata_a !== 8'h00) begin miscompares++; $display("FAIL reset_cpu_rdata: got %h want 00", cpu_rdata_a); end
      vectors++; if (dma_rdata_a !== 8'h00) begin miscompares++; $display("FAIL reset_dma_rdata: got %h want 00", dma_rdata_a); end
      vectors++; if (cpu_stall_a !== 1'b1) begin miscompares++; $display("FAIL reset_stall_req: got %b want 1", cpu_stall_a); end
      cpu_mem_enable = 1'b0;
      #1;
      vectors++; if (cpu_stall_a !== 1'b0) begin miscompares++; $display("FAIL reset_stall_noreq: got %b want 0", cpu_stall_a); end
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_cpu_read();
      int   cyc;
      int   en_cyc;
      int   st_cyc;
      int   done_cyc;
      exp_t e;
      do_reset(0);
      cyc = 0; en_cyc = 0; st_cyc = 0; done_cyc = -1;
      cpu_mem_enable = 1'b1;
      cpu_mem_mode   = MEM_MODE_READ;
      cpu_addr       = 16'h8010;
      sb.push_back('{1'b0, MEM_MODE_READ, 16'h8010, 8'h00, 8'h5A});
      while (done_cyc < 0 && cyc < 10) begin
         @(negedge clock);
         if (mem_enable_a) en_cyc++;
         if (cpu_stall_a) st_cyc++;
         if (mem_enable_a && !cpu_stall_a) begin
            done_cyc = cyc;
            e = sb.pop_front();
            vectors++; if (cpu_rdata_a !== e.rdata) begin miscompares++; $display("FAIL cpu_read_rdata: got %h want %h", cpu_rdata_a, e.rdata); end
            vectors++; if (mem_addr_a !== e.addr) begin miscompares++; $display("FAIL cpu_read_addr: got %h want %h", mem_addr_a, e.addr); end
            vectors++; if (mem_mode_a !== e.mode) begin miscompares++; $display("FAIL cpu_read_mode: got %b want %b", mem_mode_a, e.mode); end
         end
         cyc++;
      end
      vectors++; if (done_cyc !== 2) begin miscompares++; $display("FAIL cpu_read_latency: completion cycle %0d want 2", done_cyc); end
      vectors++; if (en_cyc !== 2) begin miscompares++; $display("FAIL cpu_read_enable_cycles: got %0d want 2", en_cyc); end
      vectors++; if (st_cyc !== 2) begin miscompares++; $display("FAIL cpu_read_stall_cycles: got %0d want 2", st_cyc); end
      @(posedge clock);
      #1;
      cpu_mem_enable = 1'b0;
      @(negedge clock);
      vectors++; if (mem_enable_a !== 1'b0) begin miscompares++; $display("FAIL cpu_read_idle_after: got %b want 0", mem_enable_a); end
      vectors++; if (cpu_rdata_a !== 8'h00) begin miscompares++; $display("FAIL cpu_read_rdata_idle: got %h want 00", cpu_rdata_a); end
   endtask

   task automatic test_dma_write();
      int   cyc;
      int   first_grant;
      int   grant_cyc;
      int   done_pulses;
      exp_t e;
      do_reset(0);
      cyc = 0; first_grant = -1; grant_cyc = 0; done_pulses = 0;
      dma_req   = 1'b1;
      dma_mode  = MEM_MODE_WRITE;
      dma_addr  = 16'h1234;
      dma_wdata = 8'hA5;
      sb.push_back('{1'b1, MEM_MODE_WRITE, 16'h1234, 8'hA5, 8'h00});
      while (done_pulses == 0 && cyc < 10) begin
         @(negedge clock);
         if (dma_grant_a) begin
            grant_cyc++;
            if (first_grant < 0) first_grant = cyc;
         end
         if (dma_done_a) begin
            done_pulses++;
            e = sb.pop_front();
            vectors++; if (cyc !== 2) begin miscompares++; $display("FAIL dma_write_done_cycle: got %0d want 2", cyc); end
            vectors++; if (mem_mode_a !== e.mode) begin miscompares++; $display("FAIL dma_write_mode: got %b want %b", mem_mode_a, e.mode); end
            vectors++; if (mem_addr_a !== e.addr) begin miscompares++; $display("FAIL dma_write_addr: got %h want %h", mem_addr_a, e.addr); end
            vectors++; if (mem_wdata_a !== e.wdata) begin miscompares++; $display("FAIL dma_write_wdata: got %h want %h", mem_wdata_a, e.wdata); end
         end
         cyc++;
      end
      vectors++; if (first_grant !== 1) begin miscompares++; $display("FAIL dma_write_first_grant: got %0d want 1", first_grant); end
      vectors++; if (grant_cyc !== 2) begin miscompares++; $display("FAIL dma_write_grant_cycles: got %0d want 2", grant_cyc); end
      @(posedge clock);
      #1;
      dma_req = 1'b0;
      @(negedge clock);
      if (dma_done_a) done_pulses++;
      vectors++; if (done_pulses !== 1) begin miscompares++; $display("FAIL dma_write_done_pulses: got %0d want 1", done_pulses); end
      vectors++; if (dma_grant_a !== 1'b0) begin miscompares++; $display("FAIL dma_write_grant_after: got %b want 0", dma_grant_a); end
      vectors++; if (mem_wdata_a !== 8'h00) begin miscompares++; $display("FAIL dma_write_wdata_idle: got %h want 00", mem_wdata_a); end
   endtask

   task automatic test_starve();
      int   cyc;
      int   n;
      exp_t e;
      do_reset(0);
      cpu_mem_enable = 1'b1; cpu_mem_mode = MEM_MODE_READ; cpu_addr = 16'h4000;
      dma_req        = 1'b1; dma_mode     = MEM_MODE_READ; dma_addr = 16'h2000;
      for (int i = 0; i < 10; i++) begin
         if ((i % 5) == 4) sb.push_back('{1'b1, MEM_MODE_READ, 16'h2000, 8'h00, mem_model(16'h2000)});
         else              sb.push_back('{1'b0, MEM_MODE_READ, 16'h4000, 8'h00, mem_model(16'h4000)});
      end
      cyc = 0; n = 0;
      while (sb.size() > 0 && cyc < 60) begin
         @(negedge clock);
         if (dma_done_a || (mem_enable_a && cpu_mem_enable && !cpu_stall_a && !dma_grant_a)) begin
            e = sb.pop_front();
            vectors++; if (dma_done_a !== e.is_dma) begin miscompares++; $display("FAIL starve_order[%0d]: dma owner %b want %b", n, dma_done_a, e.is_dma); end
            vectors++; if (mem_addr_a !== e.addr) begin miscompares++; $display("FAIL starve_addr[%0d]: got %h want %h", n, mem_addr_a, e.addr); end
            if (e.is_dma) begin
               vectors++; if (dma_rdata_a !== e.rdata) begin miscompares++; $display("FAIL starve_dma_rdata[%0d]: got %h want %h", n, dma_rdata_a, e.rdata); end
            end else begin
               vectors++; if (cpu_rdata_a !== e.rdata) begin miscompares++; $display("FAIL starve_cpu_rdata[%0d]: got %h want %h", n, cpu_rdata_a, e.rdata); end
            end
            n++;
         end
         cyc++;
      end
      vectors++; if (n !== 10) begin miscompares++; $display("FAIL starve_grants: got %0d want 10", n); end
      do_reset(0);
   endtask

   task automatic test_starve_zero();
      int   cyc;
      int   n;
      exp_t e;
      do_reset(1);
      cpu_mem_enable = 1'b1; cpu_mem_mode = MEM_MODE_READ;  cpu_addr = 16'h0F00; cpu_wdata = 8'h00;
      dma_req        = 1'b1; dma_mode     = MEM_MODE_WRITE; dma_addr = 16'h00F0; dma_wdata = 8'h77;
      sb.push_back('{1'b1, MEM_MODE_WRITE, 16'h00F0, 8'h77, 8'h00});
      sb.push_back('{1'b0, MEM_MODE_READ,  16'h0F00, 8'h00, mem_model(16'h0F00)});
      cyc = 0; n = 0;
      while (sb.size() > 0 && cyc < 20) begin
         @(negedge clock);
         if (dma_grant_b) begin
            vectors++; if (cpu_stall_b !== 1'b1) begin miscompares++; $display("FAIL starve0_stall_in_dma: got %b want 1", cpu_stall_b); end
         end
         if (dma_done_b || (mem_enable_b && !cpu_stall_b && !dma_grant_b)) begin
            e = sb.pop_front();
            vectors++; if (dma_done_b !== e.is_dma) begin miscompares++; $display("FAIL starve0_order[%0d]: dma owner %b want %b", n, dma_done_b, e.is_dma); end
            vectors++; if (mem_addr_b !== e.addr) begin miscompares++; $display("FAIL starve0_addr[%0d]: got %h want %h", n, mem_addr_b, e.addr); end
            if (!e.is_dma) begin
               vectors++; if (cpu_rdata_b !== e.rdata) begin miscompares++; $display("FAIL starve0_cpu_rdata: got %h want %h", cpu_rdata_b, e.rdata); end
            end
            n++;
            if (dma_done_b) begin
               @(posedge clock);
               #1;
               dma_req = 1'b0;
            end
         end
         cyc++;
      end
      vectors++; if (n !== 2) begin miscompares++; $display("FAIL starve0_grants: got %0d want 2", n); end
      do_reset(1);
   endtask

   task automatic test_back_to_back();
      logic [15:0] addrs [4] = '{16'h0100, 16'h0203, 16'hFFFF, 16'h8010};
      int   cyc;
      int   idx;
      int   last_done;
      int   stall_run;
      int   en_run;
      exp_t e;
      do_reset(2);
      for (int i = 0; i < 4; i++) sb.push_back('{1'b0, MEM_MODE_READ, addrs[i], 8'h00, mem_model(addrs[i])});
      cpu_mem_enable = 1'b1; cpu_mem_mode = MEM_MODE_READ; cpu_addr = addrs[0];
      cyc = 0; idx = 0; last_done = -1; stall_run = 0; en_run = 0;
      while (idx < 4 && cyc < 30) begin
         @(negedge clock);
         if (cpu_stall_c) stall_run++;
         if (mem_enable_c) en_run++;
         if (mem_enable_c && !cpu_stall_c) begin
            e = sb.pop_front();
            vectors++; if (cpu_rdata_c !== e.rdata) begin miscompares++; $display("FAIL ws0_rdata[%0d]: got %h want %h", idx, cpu_rdata_c, e.rdata); end
            vectors++; if (mem_addr_c !== e.addr) begin miscompares++; $display("FAIL ws0_addr[%0d]: got %h want %h", idx, mem_addr_c, e.addr); end
            vectors++; if (stall_run !== 1) begin miscompares++; $display("FAIL ws0_stall_cycles[%0d]: got %0d want 1", idx, stall_run); end
            vectors++; if (en_run !== 1) begin miscompares++; $display("FAIL ws0_enable_cycles[%0d]: got %0d want 1", idx, en_run); end
            if (last_done >= 0) begin
               vectors++; if ((cyc - last_done) !== 2) begin miscompares++; $display("FAIL ws0_period[%0d]: got %0d want 2", idx, cyc - last_done); end
            end
            last_done = cyc; stall_run = 0; en_run = 0; idx++;
            if (idx < 4) begin
               @(posedge clock);
               #1;
               cpu_addr = addrs[idx];
               cyc++;
               continue;
            end
         end
         cyc++;
      end
      vectors++; if (idx !== 4) begin miscompares++; $display("FAIL ws0_accesses: got %0d want 4", idx); end
      do_reset(2);
   endtask

   task automatic test_reset_mid_access();
      int   cyc;
      int   bad;
      exp_t e;
      do_reset(0);
      dma_req = 1'b1; dma_mode = MEM_MODE_WRITE; dma_addr = 16'h0F0F; dma_wdata = 8'h3C;
      cyc = 0;
      while (!dma_grant_a && cyc < 6) begin
         @(negedge clock);
         cyc++;
      end
      vectors++; if (dma_grant_a !== 1'b1) begin miscompares++; $display("FAIL rst_mid_grant: got %b want 1", dma_grant_a); end
      vectors++; if (dma_done_a !== 1'b0) begin miscompares++; $display("FAIL rst_mid_wait_done: got %b want 0", dma_done_a); end
      #1;
      reset_n = 1'b0;
      #1;
      vectors++; if (mem_enable_a !== 1'b0) begin miscompares++; $display("FAIL rst_mid_mem_enable: got %b want 0", mem_enable_a); end
      vectors++; if (dma_grant_a !== 1'b0) begin miscompares++; $display("FAIL rst_mid_dma_grant: got %b want 0", dma_grant_a); end
      vectors++; if (dma_done_a !== 1'b0) begin miscompares++; $display("FAIL rst_mid_dma_done: got %b want 0", dma_done_a); end
      dma_req = 1'b0;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         if (mem_enable_a || dma_done_a || dma_grant_a) bad++;
      end
      vectors++; if (bad !== 0) begin miscompares++; $display("FAIL rst_mid_idle_after: active cycles %0d want 0", bad); end
      @(posedge clock);
      #1;
      cpu_mem_enable = 1'b1; cpu_mem_mode = MEM_MODE_READ; cpu_addr = 16'h00AA;
      sb.push_back('{1'b0, MEM_MODE_READ, 16'h00AA, 8'h00, mem_model(16'h00AA)});
      cyc = 0;
      while (sb.size() > 0 && cyc < 10) begin
         @(negedge clock);
         if (mem_enable_a && !cpu_stall_a) begin
            e = sb.pop_front();
            vectors++; if (cpu_rdata_a !== e.rdata) begin miscompares++; $display("FAIL rst_mid_recover_rdata: got %h want %h", cpu_rdata_a, e.rdata); end
            vectors++; if (cyc !== 2) begin miscompares++; $display("FAIL rst_mid_recover_latency: got %0d want 2", cyc); end
         end
         cyc++;
      end
      vectors++; if (sb.size() !== 0) begin miscompares++; $display("FAIL rst_mid_recover_timeout: pending %0d want 0", sb.size()); end
      @(posedge clock);
      #1;
      cpu_mem_enable = 1'b0;
   endtask

   initial begin
      reset_n        = 1'b0;
      cpu_mem_enable = 1'b0;
      cpu_mem_mode   = MEM_MODE_READ;
      cpu_addr       = '0;
      cpu_wdata      = '0;
      dma_req        = 1'b0;
      dma_mode       = MEM_MODE_READ;
      dma_addr       = '0;
      dma_wdata      = '0;
      test_reset();
      test_cpu_read();
      test_dma_write();
      test_starve();
      test_starve_zero();
      test_back_to_back();
      test_reset_mid_access();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
